// File: rtl/openhw_arb_pkg.sv
// Shared arbiter definitions: FSM state encoding reused by the openhw arbiters.
package openhw_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/openhw_onehotdecoder.sv
// Binary-to-one-hot decoder with an enable; output is all-zero when disabled.
module openhw_onehotdecoder #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0]      idx,
  input  logic                  en,
  output logic [2**WIDTH-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/openhw_rr_arbiter.sv
// Two-state round-robin arbiter: one grant at a time, held until the holder
// pulses Done, with the priority pointer advancing past each released winner.
module openhw_rr_arbiter
  import openhw_arb_pkg::*;
#(
  parameter int IDXW = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [2**IDXW-1:0]   Req,
  input  logic                 Done,
  output logic [2**IDXW-1:0]   Grant,
  output logic [IDXW-1:0]      GrantIdx,
  output logic                 Busy
);

  localparam int N = 2**IDXW;

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] winner;
  logic            found;

  // Scan upward from the pointer; IDXW-bit addition wraps N-1 back to 0.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [IDXW-1:0] cand;
      cand = ptr_q + IDXW'(i);
      if (!found && Req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          idx_d   = winner;
        end
      end
      GRANT: begin
        if (Done) begin
          state_d = IDLE;
          ptr_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset aborts any grant outright; the pointer restarts at 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  assign Busy     = (state_q == GRANT);
  assign GrantIdx = idx_q;

  openhw_onehotdecoder #(
    .WIDTH (IDXW)
  ) u_grant_dec (
    .idx    (idx_q),
    .en     (Busy),
    .onehot (Grant)
  );

endmodule
